hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage MIPS-style core.
//   Detects load-use / late-result data hazards and multiply/divide
//   occupancy hazards for the D-stage instruction, selects the operand
//   forwarding source, tracks multiply/divide busy time, and counts
//   stall cycles since reset.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   D_rs_num/D_rt_num          D-stage source register numbers
//   D_rs_tuse/D_rt_tuse        cycles until D-stage operand use (3 = unused)
//   D_is_md                    D-stage instruction touches HI/LO or mult/div
//   E/M/W_wr_num               destination register per stage (0 = none)
//   E_tnew/M_tnew              cycles until the stage result is available
//   E_start_mult/E_start_div   one-cycle mult/div issue strobes from E
//   stall, PC_en, FD_en        pipeline freeze (PC_en = FD_en = !stall)
//   DE_clear                   bubble insert into D/E (= stall)
//   D_rs_fwd/D_rt_fwd          operand source: 0 regfile, 1 E, 2 M, 3 W
//   md_busy                    multiply/divide unit occupied
//   stall_count                saturating count of stall cycles
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_num,
    input  logic [4:0]  D_rt_num,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_wr_num,
    input  logic [4:0]  M_wr_num,
    input  logic [4:0]  W_wr_num,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        E_start_mult,
    input  logic        E_start_div,
    output logic        stall,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_clear,
    output logic [1:0]  D_rs_fwd,
    output logic [1:0]  D_rt_fwd,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    localparam int unsigned REG_W    = 5;
    localparam int unsigned TIME_W   = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t          md_state;
    logic [CNT_W-1:0]   md_cnt;
    logic               stall_rs;
    logic               stall_rt;
    logic               stall_md;

    // Source is stalled when a producer in E or M will not have its result
    // ready by the time the D-stage instruction needs it.
    function automatic logic data_stall(
        input logic [REG_W-1:0]  src,
        input logic [TIME_W-1:0] tuse,
        input logic [REG_W-1:0]  e_num,
        input logic [TIME_W-1:0] e_tnew,
        input logic [REG_W-1:0]  m_num,
        input logic [TIME_W-1:0] m_tnew
    );
        return (src != '0) &&
               (((e_num == src) && (e_tnew > tuse)) ||
                ((m_num == src) && (m_tnew > tuse)));
    endfunction

    // Youngest ready producer wins; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0]  src,
        input logic [REG_W-1:0]  e_num,
        input logic [TIME_W-1:0] e_tnew,
        input logic [REG_W-1:0]  m_num,
        input logic [TIME_W-1:0] m_tnew,
        input logic [REG_W-1:0]  w_num
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if ((e_num == src) && (e_tnew == '0)) begin
                sel = FWD_E;
            end else if ((m_num == src) && (m_tnew == '0)) begin
                sel = FWD_M;
            end else if (w_num == src) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    // Hazard detection and forwarding select; all same-cycle.
    always_comb begin
        stall_rs = data_stall(D_rs_num, D_rs_tuse, E_wr_num, E_tnew, M_wr_num, M_tnew);
        stall_rt = data_stall(D_rt_num, D_rt_tuse, E_wr_num, E_tnew, M_wr_num, M_tnew);
        md_busy  = E_start_mult || E_start_div || (md_cnt != '0);
        stall_md = D_is_md && md_busy;
        stall    = stall_rs || stall_rt || stall_md;
        PC_en    = !stall;
        FD_en    = !stall;
        DE_clear = stall;
        D_rs_fwd = fwd_sel(D_rs_num, E_wr_num, E_tnew, M_wr_num, M_tnew, W_wr_num);
        D_rt_fwd = fwd_sel(D_rt_num, E_wr_num, E_tnew, M_wr_num, M_tnew, W_wr_num);
    end

    // Mult/div occupancy: the strobe cycle itself is covered by md_busy,
    // so the counter only needs to hold the remaining busy cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (E_start_div) begin
                        md_cnt   <= CNT_W'(DIV_CYC);
                        md_state <= MD_BUSY;
                    end else if (E_start_mult) begin
                        md_cnt   <= CNT_W'(MULT_CYC);
                        md_state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - CNT_W'(1);
                    if (md_cnt == CNT_W'(1)) begin
                        md_state <= MD_IDLE;
                    end
                end
                default: begin
                    md_state <= MD_IDLE;
                    md_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs_num;
    logic [4:0]  D_rt_num;
    logic [1:0]  D_rs_tuse;
    logic [1:0]  D_rt_tuse;
    logic        D_is_md;
    logic [4:0]  E_wr_num;
    logic [4:0]  M_wr_num;
    logic [4:0]  W_wr_num;
    logic [1:0]  E_tnew;
    logic [1:0]  M_tnew;
    logic        E_start_mult;
    logic        E_start_div;
    logic        stall;
    logic        PC_en;
    logic        FD_en;
    logic        DE_clear;
    logic [1:0]  D_rs_fwd;
    logic [1:0]  D_rt_fwd;
    logic        md_busy;
    logic [31:0] stall_count;

    int tests_run;
    int tests_failed;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs_num     (D_rs_num),
        .D_rt_num     (D_rt_num),
        .D_rs_tuse    (D_rs_tuse),
        .D_rt_tuse    (D_rt_tuse),
        .D_is_md      (D_is_md),
        .E_wr_num     (E_wr_num),
        .M_wr_num     (M_wr_num),
        .W_wr_num     (W_wr_num),
        .E_tnew       (E_tnew),
        .M_tnew       (M_tnew),
        .E_start_mult (E_start_mult),
        .E_start_div  (E_start_div),
        .stall        (stall),
        .PC_en        (PC_en),
        .FD_en        (FD_en),
        .DE_clear     (DE_clear),
        .D_rs_fwd     (D_rs_fwd),
        .D_rt_fwd     (D_rt_fwd),
        .md_busy      (md_busy),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        D_rs_num = '0; D_rt_num = '0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        D_is_md = 1'b0; E_wr_num = '0; M_wr_num = '0; W_wr_num = '0;
        E_tnew = '0; M_tnew = '0; E_start_mult = 1'b0; E_start_div = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_inputs();
        D_rs_tuse = '0; D_rt_tuse = '0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        #1;

        // Reset state with all inputs zero.
        check("rst_stall",    32'(stall),    32'd0);
        check("rst_pc_en",    32'(PC_en),    32'd1);
        check("rst_fd_en",    32'(FD_en),    32'd1);
        check("rst_de_clear", 32'(DE_clear), 32'd0);
        check("rst_rs_fwd",   32'(D_rs_fwd), 32'd0);
        check("rst_rt_fwd",   32'(D_rt_fwd), 32'd0);
        check("rst_md_busy",  32'(md_busy),  32'd0);
        check("rst_cnt",      stall_count,   32'd0);

        // E-stage producer not ready in time.
        clear_inputs();
        E_wr_num = 5'd8; E_tnew = 2'd2; D_rs_num = 5'd8; D_rs_tuse = 2'd1;
        #1;
        check("e_stall",      32'(stall),    32'd1);
        check("e_de_clear",   32'(DE_clear), 32'd1);
        check("e_pc_en",      32'(PC_en),    32'd0);
        check("e_fd_en",      32'(FD_en),    32'd0);
        E_tnew = 2'd1;
        #1;
        check("e_tnew_eq_tuse", 32'(stall),    32'd0);
        check("e_no_fwd",       32'(D_rs_fwd), 32'd0);

        // M-stage producer, same boundary.
        E_wr_num = '0; M_wr_num = 5'd8; M_tnew = 2'd2;
        #1;
        check("m_stall", 32'(stall), 32'd1);
        M_tnew = 2'd1;
        #1;
        check("m_tnew_eq_tuse", 32'(stall), 32'd0);

        // rt forwarding priority E > M > W.
        clear_inputs();
        E_wr_num = 5'd9; E_tnew = 2'd0; M_wr_num = 5'd9; M_tnew = 2'd0;
        D_rt_num = 5'd9; D_rt_tuse = 2'd0;
        #1;
        check("rt_fwd_e", 32'(D_rt_fwd), 32'd1);
        E_wr_num = '0;
        #1;
        check("rt_fwd_m", 32'(D_rt_fwd), 32'd2);
        M_wr_num = '0; W_wr_num = 5'd9;
        #1;
        check("rt_fwd_w", 32'(D_rt_fwd), 32'd3);

        // Register 0 never forwards or stalls even with matching zero dests.
        W_wr_num = '0; D_rt_num = '0; E_tnew = 2'd2; M_tnew = 2'd2;
        #1;
        check("r0_rt_fwd", 32'(D_rt_fwd), 32'd0);
        check("r0_stall",  32'(stall),    32'd0);

        // rs: E match but not ready falls through to ready M.
        clear_inputs();
        D_rs_num = 5'd5; D_rs_tuse = 2'd1;
        E_wr_num = 5'd5; E_tnew = 2'd1; M_wr_num = 5'd5; M_tnew = 2'd0;
        #1;
        check("rs_fwd_m_skip_e", 32'(D_rs_fwd), 32'd2);
        check("rs_no_stall",     32'(stall),    32'd0);
        check("cnt_still_zero",  stall_count,   32'd0);

        // Mult: busy 6 cycles, D_is_md stalls cycles 1..5.
        clear_inputs();
        E_start_mult = 1'b1;
        #1;
        check("mult_c0_busy", 32'(md_busy), 32'd1);
        check("mult_c0_stall", 32'(stall), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            E_start_mult = 1'b0;
            D_is_md = 1'b1;
            #1;
            check($sformatf("mult_c%0d_busy", c),  32'(md_busy), (c <= 5) ? 32'd1 : 32'd0);
            check($sformatf("mult_c%0d_stall", c), 32'(stall),   (c <= 5) ? 32'd1 : 32'd0);
        end
        check("mult_stall_cnt", stall_count, 32'd5);
        D_is_md = 1'b0;

        // Div + mult together: div wins, 11 busy cycles, mid-busy mult ignored.
        cyc();
        E_start_div = 1'b1; E_start_mult = 1'b1;
        #1;
        check("div_c0_busy", 32'(md_busy), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            E_start_div = 1'b0;
            E_start_mult = (c == 3);
            #1;
            check($sformatf("div_c%0d_busy", c), 32'(md_busy), (c <= 10) ? 32'd1 : 32'd0);
        end
        E_start_mult = 1'b0;

        // Reset during a div clears busy and the stall counter.
        cyc();
        E_start_div = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            E_start_div = 1'b0;
            D_is_md = (c <= 3);
            reset = (c == 4);
            #1;
            if (c == 4) begin
                check("rst_mid_pre_cnt", stall_count, 32'd8);
                check("rst_mid_pre_busy", 32'(md_busy), 32'd1);
            end
        end
        check("rst_mid_busy", 32'(md_busy), 32'd0);
        check("rst_mid_cnt",  stall_count,  32'd0);

        // Saturation of stall_count.
        clear_inputs();
        force dut.stall_count = 32'hFFFF_FFFE;
        cyc();
        release dut.stall_count;
        #1;
        check("sat_preload", stall_count, 32'hFFFF_FFFE);
        E_wr_num = 5'd8; E_tnew = 2'd2; D_rs_num = 5'd8; D_rs_tuse = 2'd1;
        cyc();
        check("sat_first",  stall_count, 32'hFFFF_FFFF);
        cyc();
        check("sat_no_wrap", stall_count, 32'hFFFF_FFFF);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
